// File: rtl/echo_pkg.sv
// echo_pkg: read-sequencer state encoding and default sizing shared
// by the echo FIFO controller and its environment.
package echo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DEPTH      = 64;

    typedef enum logic [1:0] {
        FLUSH = 2'd0,
        IDLE  = 2'd1,
        FETCH = 2'd2,
        VALID = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/echo_fifo_ctrl_if.sv
// echo_fifo_ctrl_if: valid/ready byte stream used for the UART RX side
// (controller is slave) and the UART TX side (controller is master).
interface echo_fifo_ctrl_if
    import echo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );

endinterface

// File: rtl/echo_fifo_ctrl.sv
// echo_fifo_ctrl: guards and sequences an unreset echo FIFO, flushing it
// after reset. ECHO_FIFO_CTRL_WATERMARK_EN adds a registered almost_full.
module echo_fifo_ctrl
    import echo_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int DEPTH       = DEF_DEPTH
`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
    ,
    parameter int AFULL_LEVEL = DEPTH - 4
`endif
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    echo_fifo_ctrl_if.slave       s,
    echo_fifo_ctrl_if.master      m,
    output logic                  fifo_w_enable,
    output logic [DATA_WIDTH-1:0] fifo_w_data,
    output logic                  fifo_r_enable,
    input  logic [DATA_WIDTH-1:0] fifo_r_data,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  full,
    output logic                  empty
`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
    ,
    output logic                  almost_full
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    ctrl_state_t           state;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  has_data;
    logic                  rd_en;

    assign has_data = (fifo_count != '0);

    assign s.ready       = (state != FLUSH) && (fifo_count < DEPTH_W);
    assign fifo_w_enable = s.valid && s.ready;
    assign fifo_w_data   = s.data;

    assign m.valid = valid_q;
    assign m.data  = data_q;

    assign full  = (fifo_count >= DEPTH_W);
    assign empty = !has_data && !valid_q;

    always_comb begin
        rd_en = 1'b0;
        unique case (state)
            FLUSH:   rd_en = has_data;
            IDLE:    rd_en = has_data;
            VALID:   rd_en = has_data && m.ready;
            default: rd_en = 1'b0;
        endcase
    end

    // The FIFO has no reset, so no strobe may escape while RST_N is low.
    assign fifo_r_enable = RST_N && rd_en;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state   <= FLUSH;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            unique case (state)
                FLUSH: begin
                    if (!has_data)
                        state <= IDLE;
                end
                IDLE: begin
                    if (has_data)
                        state <= FETCH;
                end
                FETCH: begin
                    data_q  <= fifo_r_data;
                    valid_q <= 1'b1;
                    state   <= VALID;
                end
                VALID: begin
                    if (m.ready) begin
                        valid_q <= 1'b0;
                        state   <= has_data ? FETCH : IDLE;
                    end
                end
                default: state <= FLUSH;
            endcase
        end
    end

`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
    localparam logic [ADDR_WIDTH:0] AFULL_W = (ADDR_WIDTH+1)'(AFULL_LEVEL);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            almost_full <= 1'b0;
        else
            almost_full <= (fifo_count >= AFULL_W);
    end
`endif

endmodule

// File: tb/tb_echo_fifo_ctrl.sv
// tb_echo_fifo_ctrl: directed stimulus against an unreset FIFO model,
// with a queue scoreboard checking every downstream word.
module tb_echo_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int DEPTH = 64;

    logic          CLK = 1'b0;
    logic          RST_N;
    logic          fifo_w_enable;
    logic [DW-1:0] fifo_w_data;
    logic          fifo_r_enable;
    logic [DW-1:0] fifo_r_data = '0;
    logic [AW:0]   fifo_count = '0;
    logic          full;
    logic          empty;
`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
    logic          almost_full;
`endif

    echo_fifo_ctrl_if #(.DATA_WIDTH(DW)) s_if ();
    echo_fifo_ctrl_if #(.DATA_WIDTH(DW)) m_if ();

    echo_fifo_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .s             (s_if.slave),
        .m             (m_if.master),
        .fifo_w_enable (fifo_w_enable),
        .fifo_w_data   (fifo_w_data),
        .fifo_r_enable (fifo_r_enable),
        .fifo_r_data   (fifo_r_data),
        .fifo_count    (fifo_count),
        .full          (full),
        .empty         (empty)
`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
        ,
        .almost_full   (almost_full)
`endif
    );

    always #5 CLK = ~CLK;

    // FIFO model: no reset, registered read data, preload hook.
    logic [DW-1:0] mem [0:255];
    logic [7:0]    wp = '0;
    logic [7:0]    rp = '0;
    int            load_n = 0;

    always @(posedge CLK) begin
        if (load_n != 0) begin
            for (int i = 0; i < load_n; i++)
                mem[8'(int'(wp) + i)] <= 8'(8'hE0 + i);
            wp         <= 8'(int'(wp) + load_n);
            fifo_count <= fifo_count + 9'(load_n);
        end else begin
            if (fifo_w_enable) begin
                mem[wp] <= fifo_w_data;
                wp      <= wp + 8'd1;
            end
            if (fifo_r_enable) begin
                fifo_r_data <= mem[rp];
                rp          <= rp + 8'd1;
            end
            fifo_count <= fifo_count + {8'd0, fifo_w_enable}
                                     - {8'd0, fifo_r_enable};
        end
    end

    int cmp_cnt = 0;
    int err_cnt = 0;
    int r_cnt = 0;
    logic [DW-1:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: push accepted words, pop and compare delivered words.
    always @(negedge CLK) begin
        if (!RST_N) begin
            expq.delete();
        end else begin
            if (fifo_r_enable)
                r_cnt++;
            if (fifo_w_enable)
                chk("no_write_when_full", 32'(fifo_count < 9'(DEPTH)), 1);
            if (s_if.valid && s_if.ready)
                expq.push_back(s_if.data);
            if (m_if.valid && m_if.ready) begin
                if (expq.size() == 0) begin
                    cmp_cnt++;
                    err_cnt++;
                    $display("FAIL out_unexpected: got 0x%0h, want none",
                             m_if.data);
                end else begin
                    chk("out_data", m_if.data, expq.pop_front());
                end
            end
        end
    end

    task automatic put(input logic [DW-1:0] b);
        s_if.valid = 1'b1;
        s_if.data  = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (n < 10) begin
            @(negedge CLK);
            if (m_if.valid)
                break;
            n++;
        end
        chk(name, m_if.valid, 1);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        m_if.ready = 1'b1;
        while (expq.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK);
        #1;
        m_if.ready = 1'b0;
        chk("drain_left", expq.size(), 0);
    endtask

    task automatic wait_flush(input string name, input int reads,
                              input int cycles);
        int base = r_cnt;
        int n = 0;
        while (n < 80) begin
            @(negedge CLK);
            if (s_if.ready)
                break;
            n++;
        end
        chk({name, "_cycles"}, n, cycles);
        chk({name, "_reads"}, r_cnt - base, reads);
        chk({name, "_count"}, fifo_count, 0);
        chk({name, "_m_valid"}, m_if.valid, 0);
        chk({name, "_empty"}, empty, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int lat;
        RST_N      = 1'b0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        m_if.ready = 1'b0;

        // 1: flush of five stale words
        repeat (2) @(negedge CLK);
        load_n = 5;
        @(negedge CLK);
        load_n = 0;
        chk("rst_m_valid", m_if.valid, 0);
        chk("rst_m_data", m_if.data, 0);
        chk("rst_s_ready", s_if.ready, 0);
        chk("rst_r_enable", fifo_r_enable, 0);
        chk("rst_count", fifo_count, 5);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_flush("flush", 5, 6);

        // 2: single word latency
        @(posedge CLK);
        #1;
        put(8'hA5);
        s_if.valid = 1'b0;
        lat = 1;
        while (lat < 10) begin
            @(negedge CLK);
            if (m_if.valid)
                break;
            lat++;
        end
        chk("latency", lat, 3);
        chk("first_data", m_if.data, 8'hA5);
        @(posedge CLK);
        #1;
        m_if.ready = 1'b1;
        @(posedge CLK);
        #1;
        m_if.ready = 1'b0;
        @(negedge CLK);
        chk("single_empty", empty, 1);
        chk("single_m_valid", m_if.valid, 0);

        // 3: fill to full with downstream stalled
        k = 0;
        @(posedge CLK);
        #1;
        for (int c = 0; c < 70; c++) begin
            s_if.valid = 1'b1;
            s_if.data  = 8'(k);
            @(negedge CLK);
            if (s_if.ready)
                k++;
`ifdef ECHO_FIFO_CTRL_WATERMARK_EN
            if (fifo_count == 9'd60)
                chk("afull_at_60", almost_full, 0);
            if (fifo_count == 9'd61)
                chk("afull_after_60", almost_full, 1);
`endif
            @(posedge CLK);
            #1;
        end
        s_if.valid = 1'b0;
        @(negedge CLK);
        chk("fill_accepted", k, 65);
        chk("fill_full", full, 1);
        chk("fill_s_ready", s_if.ready, 0);
        chk("fill_count", fifo_count, 64);
        chk("fill_empty", empty, 0);
        drain(400);
        chk("fill_drained_empty", empty, 1);

        // 4: stall stability, then back-to-back spacing
        put(8'h11);
        put(8'h22);
        s_if.valid = 1'b0;
        wait_valid("stall_wait");
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("stall_valid", m_if.valid, 1);
            chk("stall_data", m_if.data, 8'h11);
        end
        @(posedge CLK);
        #1;
        m_if.ready = 1'b1;
        @(posedge CLK);
        #1;
        m_if.ready = 1'b0;
        @(negedge CLK);
        chk("gap_valid", m_if.valid, 0);
        @(negedge CLK);
        chk("next_valid", m_if.valid, 1);
        chk("next_data", m_if.data, 8'h22);
        drain(20);

        // 5: simultaneous write and read at count 3
        put(8'h30);
        put(8'h31);
        put(8'h32);
        put(8'h33);
        s_if.data  = 8'h34;
        m_if.ready = 1'b1;
        @(negedge CLK);
        chk("wr_rd_count_before", fifo_count, 3);
        chk("wr_rd_w_enable", fifo_w_enable, 1);
        chk("wr_rd_r_enable", fifo_r_enable, 1);
        @(posedge CLK);
        #1;
        s_if.valid = 1'b0;
        m_if.ready = 1'b0;
        @(negedge CLK);
        chk("wr_rd_count_after", fifo_count, 3);
        drain(40);

        // 6: reset mid-stream, flush, resume
        for (int i = 0; i < 6; i++)
            put(8'(8'h40 + i));
        s_if.valid = 1'b0;
        wait_valid("mid_wait");
        repeat (4) @(negedge CLK);
        chk("mid_count", fifo_count, 5);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        chk("async_m_valid", m_if.valid, 0);
        chk("async_m_data", m_if.data, 0);
        chk("async_s_ready", s_if.ready, 0);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        wait_flush("reflush", 5, 6);
        @(posedge CLK);
        #1;
        put(8'h50);
        put(8'h51);
        s_if.valid = 1'b0;
        drain(40);
        @(negedge CLK);
        chk("resume_empty", empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/echo_fifo_ctrl.md
Name: echo_fifo_ctrl

Overview:
Sequencer and guard for the unprotected echo FIFO. It sits between the UART RX byte stream (upstream) and the UART TX byte stream (downstream). It turns valid/ready handshakes into FIFO w_enable/r_enable, so the FIFO is never written when full or read when empty. It absorbs the FIFO's 1-cycle registered read latency and flushes stale FIFO contents after reset.

Parameters:
ADDR_WIDTH, 8, FIFO address width; fifo_count is ADDR_WIDTH+1 bits
DATA_WIDTH, 8, byte/word width
DEPTH, 64, usable FIFO capacity in entries; must be >= 2 and <= 2**ADDR_WIDTH

Ports:
CLK  in  1  system clock, all logic on rising edge
RST_N  in  1  asynchronous active-low reset
s_valid  in  1  upstream word available
s_ready  out  1  controller accepts upstream word this cycle
s_data  in  DATA_WIDTH  upstream word
m_valid  out  1  downstream word available
m_ready  in  1  downstream consumes word this cycle
m_data  out  DATA_WIDTH  downstream word (registered)
fifo_w_enable  out  1  FIFO write strobe
fifo_w_data  out  DATA_WIDTH  FIFO write data
fifo_r_enable  out  1  FIFO read strobe
fifo_r_data  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_r_enable
fifo_count  in  ADDR_WIDTH+1  FIFO occupancy
full  out  1  fifo_count >= DEPTH
empty  out  1  fifo_count == 0 and m_valid == 0

Behaviour:
- One clock domain: CLK. Reset is asynchronous, active-low, on RST_N. The FIFO itself has no reset; the controller compensates by flushing.
- Reset values: m_valid=0, m_data=0, state=FLUSH, fifo_r_enable=0. s_ready is held at 0 while in FLUSH.
- Write path (combinational):
  - s_ready = (state != FLUSH) && (fifo_count < DEPTH).
  - fifo_w_enable = s_valid && s_ready.
  - fifo_w_data = s_data.
  - A write is never issued when fifo_count >= DEPTH, and is never issued in FLUSH.
- Read FSM states: FLUSH, IDLE, FETCH, VALID.
  - FLUSH: fifo_r_enable = (fifo_count != 0); read data is discarded. When fifo_count == 0, go to IDLE. Leaves FLUSH at most DEPTH+1 cycles after reset release.
  - IDLE: m_valid=0. If fifo_count != 0, assert fifo_r_enable and go to FETCH.
  - FETCH: fifo_r_data is valid this cycle. Latch it into m_data and go to VALID. No read is issued.
  - VALID: m_valid=1, m_data held stable.
    - m_ready=1 and fifo_count != 0: assert fifo_r_enable, go to FETCH.
    - m_ready=1 and fifo_count == 0: go to IDLE.
    - m_ready=0: stay in VALID.
- fifo_r_enable is asserted only in FLUSH, IDLE or VALID, and only when fifo_count != 0.
- Latency: an upstream accept at cycle 0 with an empty FIFO and IDLE state produces m_valid=1 at cycle 3 (count=1 at c1, read at c1, FETCH at c2, VALID at c3).
- Throughput: one word per 2 cycles sustained. This is sufficient for UART rates.
- Simultaneous write and read in the same cycle are both allowed; FIFO count is unchanged.
- full/empty are combinational from fifo_count, m_valid and state.
- m_data and m_valid must not change while m_valid=1 && m_ready=0.
- Reset asserted mid-operation: all state clears immediately. The in-flight word and the m_data word are lost. Remaining FIFO contents are flushed after reset release.

Optional Feature:
Macro ECHO_FIFO_CTRL_WATERMARK_EN.
- Defined: adds parameter AFULL_LEVEL (default DEPTH-4) and output almost_full.
  - almost_full is registered, reset 0, and equals (fifo_count >= AFULL_LEVEL).
  - Intended to drive the UART RTS line.
- Not defined: no parameter, no port, no extra logic.

Decomposition:
- Shared package echo_pkg: the state encoding (FLUSH=2'd0, IDLE=2'd1, FETCH=2'd2, VALID=2'd3) and the default DATA_WIDTH/ADDR_WIDTH/DEPTH constants.
- No sub-module; this is a single flat module.
- The FIFO is instantiated by the parent alongside this block, not inside it.

Test Plan:
1. Release reset with the FIFO model preloaded to count=5 -> exactly 5 fifo_r_enable pulses, s_ready=0 throughout, then IDLE with m_valid=0 and s_ready=1.
2. Single write of 0xA5 into an empty FIFO at cycle 0 -> m_valid=1 with m_data=0xA5 at cycle 3; one m_ready pulse returns to IDLE and empty=1.
3. Hold m_ready=0 and stream 70 writes with DEPTH=64 -> s_ready drops when fifo_count=64, full=1, no w_enable while full; data out matches input order 0..64.
4. With m_ready held low in VALID, apply 10 cycles -> m_data and m_valid stable; release -> next word follows two cycles later.
5. Write and read in the same cycle at fifo_count=3 -> fifo_count stays 3 and no ordering error.
6. Assert RST_N low mid-stream for one cycle -> m_valid drops asynchronously, FLUSH drains the FIFO to count=0, and the stream resumes cleanly. Also build with ECHO_FIFO_CTRL_WATERMARK_EN and check almost_full rises the cycle after count reaches 60.
